// File: rtl/regfile_dumper.sv
// Streams register-file contents x0..xNREGS-1 (optionally from x1) as valid/ready beats.
// One capture cycle per register; abort and async reset discard the dump without done.
module regfile_dumper #(
  parameter int unsigned NREGS   = 32,
  parameter bit          SKIP_X0 = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  ra,
  input  logic [31:0] rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_idx,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LastIdx  = 5'(NREGS - 1);
  localparam logic [4:0] FirstIdx = SKIP_X0 ? 5'd1 : 5'd0;

  typedef enum logic [1:0] {StIdle, StFetch, StSend, StFin} state_e;

  state_e     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic       capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= 5'd0;
      out_data <= 32'd0;
      out_idx  <= 5'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture) begin
        out_data <= rd;
        out_idx  <= idx_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          idx_d   = FirstIdx;
        end
      end
      StFetch: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          capture = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        // abort wins over a handshake in the same cycle
        if (abort) begin
          state_d = StIdle;
        end else if (out_ready) begin
          if (out_last) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = StFetch;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign ra        = idx_q;
  assign out_valid = (state_q == StSend);
  assign out_last  = out_valid && (out_idx == LastIdx);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFin);

endmodule

// File: tb/tb_regfile_dumper.sv
// Directed bench for regfile_dumper: a 32-register instance and an 8-register instance
// that skips x0, sharing one register-file model.
module tb_regfile_dumper;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b, abort, out_ready;
  logic [31:0] rf [32];

  logic [4:0]  ra_a, ra_b, oidx_a, oidx_b;
  logic [31:0] rd_a, rd_b, dat_a, dat_b;
  logic        vld_a, vld_b, lst_a, lst_b, bsy_a, bsy_b, dn_a, dn_b;

  assign rd_a = rf[ra_a];
  assign rd_b = rf[ra_b];

  regfile_dumper #(.NREGS(32), .SKIP_X0(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort), .ra(ra_a), .rd(rd_a),
    .out_valid(vld_a), .out_ready(out_ready), .out_data(dat_a), .out_idx(oidx_a),
    .out_last(lst_a), .busy(bsy_a), .done(dn_a)
  );

  regfile_dumper #(.NREGS(8), .SKIP_X0(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort), .ra(ra_b), .rd(rd_b),
    .out_valid(vld_b), .out_ready(out_ready), .out_data(dat_b), .out_idx(oidx_b),
    .out_last(lst_b), .busy(bsy_b), .done(dn_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Selected-instance view used by the dump task
  bit          sel = 1'b0;
  logic        vld, lst, bsy, dn;
  logic [31:0] dat;
  logic [4:0]  oidx;
  always_comb begin
    vld  = sel ? vld_b  : vld_a;
    lst  = sel ? lst_b  : lst_a;
    bsy  = sel ? bsy_b  : bsy_a;
    dn   = sel ? dn_b   : dn_a;
    dat  = sel ? dat_b  : dat_a;
    oidx = sel ? oidx_b : oidx_a;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Runs one dump on instance s; optionally withholds out_ready for stall_len cycles at stall_idx.
  // Latency counts cycles inclusive of the start cycle and the done cycle.
  task automatic dump(input bit s, input int first, input int n, input int stall_idx,
                      input int stall_len);
    int beats;
    int stalls;
    int ts;
    bit seen_done;
    beats = 0;
    stalls = 0;
    seen_done = 1'b0;
    sel = s;
    out_ready = 1'b1;
    if (s) start_b = 1'b1;
    else   start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    ts = cyc;
    for (int k = 0; k < 300 && !seen_done; k++) begin
      if (dn) begin
        seen_done = 1'b1;
      end else if (vld) begin
        if (int'(oidx) == stall_idx && stalls < stall_len) begin
          out_ready = 1'b0;
          check("stall_data", dat, stall_idx * 32'h11);
          check("stall_idx", {27'd0, oidx}, stall_idx);
          stalls++;
        end else begin
          out_ready = 1'b1;
          check("beat_idx", {27'd0, oidx}, first + beats);
          check("beat_data", dat, (first + beats) * 32'h11);
          check("beat_last", {31'd0, lst}, {31'd0, beats == n - 1});
          beats++;
        end
      end
      if (!seen_done) begin
        @(posedge clk); #1;
      end
    end
    check("done_seen", {31'd0, seen_done}, 1);
    check("beat_count", beats, n);
    check("latency", cyc - ts + 2, 2 * n + 2 + stall_len);
    @(posedge clk); #1;
    check("done_pulse", {31'd0, dn}, 0);
    check("idle_after", {31'd0, bsy}, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = i * 32'h11;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_ra", {27'd0, ra_a}, 0);
    check("rst_valid", {31'd0, vld_a}, 0);
    check("rst_data", dat_a, 0);
    check("rst_idx", {27'd0, oidx_a}, 0);
    check("rst_last", {31'd0, lst_a}, 0);
    check("rst_busy", {31'd0, bsy_a}, 0);
    check("rst_done", {31'd0, dn_a}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full dump, then the same with backpressure on idx 3
    dump(1'b0, 0, 32, -1, 0);
    dump(1'b0, 0, 32, 3, 5);

    // NREGS=8, SKIP_X0=1
    dump(1'b1, 1, 7, -1, 0);

    // Abort during SEND of idx 10 with a simultaneous handshake
    sel = 1'b0;
    out_ready = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int k = 0; k < 100 && !(vld_a && oidx_a == 5'd10); k++) begin
      @(posedge clk); #1;
    end
    check("abort_reach", {31'd0, vld_a && oidx_a == 5'd10}, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", {31'd0, vld_a}, 0);
    check("abort_busy", {31'd0, bsy_a}, 0);
    check("abort_done", {31'd0, dn_a}, 0);
    check("abort_ra_hold", {27'd0, ra_a}, 10);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("abort_quiet", {30'd0, vld_a, dn_a}, 0);
    end
    dump(1'b0, 0, 32, -1, 0);

    // Hold idx 5 pending, rewrite x5, pulse start while busy, then reset mid-FETCH
    sel = 1'b0;
    out_ready = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int k = 0; k < 100 && !(vld_a && oidx_a == 5'd5); k++) begin
      @(posedge clk); #1;
    end
    check("hold_reach", {31'd0, vld_a && oidx_a == 5'd5}, 1);
    out_ready = 1'b0;
    rf[5] = 32'hDEAD_BEEF;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("hold_data", dat_a, 32'h55);
    check("hold_idx", {27'd0, oidx_a}, 5);
    check("hold_valid", {31'd0, vld_a}, 1);
    @(posedge clk); #1;
    check("hold_data2", dat_a, 32'h55);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("fetch6_busy", {31'd0, bsy_a}, 1);
    check("fetch6_valid", {31'd0, vld_a}, 0);
    check("fetch6_ra", {27'd0, ra_a}, 6);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ra", {27'd0, ra_a}, 0);
    check("arst_data", dat_a, 0);
    check("arst_idx", {27'd0, oidx_a}, 0);
    check("arst_flags", {28'd0, vld_a, lst_a, bsy_a, dn_a}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rf[5] = 32'h55;
    @(posedge clk); #1;
    check("post_rst_done", {31'd0, dn_a}, 0);
    dump(1'b0, 0, 32, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_dumper.md
REGFILE_DUMPER -- requirements
Module: regfile_dumper

Interface
REQ-001 The block SHALL have parameter NREGS, default 32, meaning the number of registers dumped (x0..xNREGS-1), legal range 2..32.
REQ-002 The block SHALL have parameter SKIP_X0, default 0, meaning that when 1 the dump starts at x1 instead of x0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a dump, sampled only in IDLE.
REQ-006 The block SHALL have port abort, input, 1 bit: cancels a dump in progress.
REQ-007 The block SHALL have port ra, output, 5 bits: address driven to a register-file read port.
REQ-008 The block SHALL have port rd, input, 32 bits: combinational read data returned for ra.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data/out_idx/out_last hold a valid beat.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the beat.
REQ-011 The block SHALL have port out_data, output, 32 bits: the captured register value.
REQ-012 The block SHALL have port out_idx, output, 5 bits: the register index of out_data.
REQ-013 The block SHALL have port out_last, output, 1 bit: marks the beat for index NREGS-1.
REQ-014 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a dump completes normally.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, SEND and FIN.
REQ-017 In IDLE with start=1, the next state SHALL be FETCH, with idx loaded to SKIP_X0 ? 1 : 0.
REQ-018 ra SHALL equal idx in every state; in IDLE idx holds its last value.
REQ-019 In FETCH, the block SHALL register rd into out_data and idx into out_idx, and the next state SHALL be SEND; each register therefore costs one capture cycle.
REQ-020 out_valid SHALL be 1 exactly in SEND.
REQ-021 out_last SHALL be 1 in SEND when out_idx = NREGS-1, and 0 otherwise.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL stay stable.
REQ-023 A handshake in SEND (out_valid & out_ready) with out_last=0 SHALL increment idx and move to FETCH.
REQ-024 A handshake in SEND with out_last=1 SHALL move to FIN.
REQ-025 FIN SHALL assert done for one cycle and then return to IDLE.
REQ-026 Minimum dump length with out_ready held at 1 SHALL be 2*N+2 cycles from start to done, where N = NREGS - SKIP_X0.
REQ-027 start SHALL be ignored while busy=1; start held at 1 in IDLE SHALL begin a new dump in the cycle after FIN.
REQ-028 abort=1 in FETCH or SEND SHALL force IDLE on the next edge, drop out_valid without a handshake, and leave done at 0; abort has priority over a simultaneous handshake.
REQ-029 abort in IDLE or FIN SHALL have no effect.
REQ-030 The value captured SHALL be the rd present in the FETCH cycle; register-file writes after capture SHALL NOT alter a pending beat.
REQ-031 idx SHALL never exceed NREGS-1 and SHALL never wrap.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, idx=0, out_data=0, out_idx=0, out_valid=0, out_last=0, busy=0 and done=0, regardless of clk.
REQ-033 rst asserted mid-dump SHALL discard the dump with no done pulse; the first dump after rst deasserts SHALL start from the beginning.

Verification
REQ-034 Full dump: regfile xi=i*0x11, out_ready=1, start pulse -> 32 beats, out_idx 0..31, out_data i*0x11, out_last only on idx 31, done 66 cycles after start.
REQ-035 Backpressure: out_ready=0 for 5 cycles on idx 3 -> out_data=0x33 and out_idx=3 held stable, then the dump resumes with idx 4 and no beat is lost or duplicated.
REQ-036 SKIP_X0=1, NREGS=8 -> 7 beats idx 1..7, out_last on idx 7, done 16 cycles after start.
REQ-037 Abort during SEND of idx 10 with out_ready=1 in the same cycle -> no further beats, no done, busy=0 the next cycle; a later start dumps from idx 0.
REQ-038 Async reset mid-FETCH between clock edges -> all outputs 0 immediately; start ignored while busy; a write to x5 after its capture does not change the pending beat for idx 5.
